// File: rtl/ofmap_tx_pkg.sv
// Shared NPU definitions for the output-feature-map transmitter:
// FSM state encoding, INT8 saturation limits and control field widths.
package ofmap_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int INT8_MIN = -128;
  localparam int INT8_MAX = 127;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned SHIFT_W = 5;

endpackage

// File: rtl/ofmap_fifo.sv
// Synchronous beat buffer; head is forced to zero while empty so the
// AXI-Stream payload reads 0 whenever no beat is pending.
module ofmap_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Pointer increment that wraps at DEPTH even when DEPTH is not a power of two
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wrap_inc(wr_ptr);
      if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ofmap_tx.sv
// Requantizes signed psums to saturated int8, packs PACK lanes per beat and
// streams the beats out over AXI-Stream through a small FIFO.
module ofmap_tx
  import ofmap_tx_pkg::*;
#(
  parameter int unsigned PSUM_BW    = 32,
  parameter int unsigned OUT_BW     = 8,
  parameter int unsigned PACK       = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CNT_W-1:0]       total_cnt,
  input  logic [SHIFT_W-1:0]     shift,
  input  logic                   psum_valid,
  input  logic [PSUM_BW-1:0]     psum,
  output logic                   psum_ready,
  output logic [PACK*OUT_BW-1:0] m_axis_tdata,
  output logic [PACK-1:0]        m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned DATA_W  = PACK * OUT_BW;
  localparam int unsigned ENTRY_W = DATA_W + PACK + 1;
  localparam int unsigned LANE_W  = (PACK > 1) ? $clog2(PACK) : 1;

  localparam logic signed [PSUM_BW:0] SAT_MAX = (PSUM_BW + 1)'(INT8_MAX);
  localparam logic signed [PSUM_BW:0] SAT_MIN = (PSUM_BW + 1)'(INT8_MIN);

  state_t                   state;
  state_t                   state_nx;
  logic [CNT_W-1:0]         total_q;
  logic [SHIFT_W-1:0]       shift_q;
  logic [CNT_W-1:0]         elem_cnt;
  logic [LANE_W-1:0]        lane;
  logic [DATA_W-1:0]        beat_data;
  logic [PACK-1:0]          beat_keep;
  logic [DATA_W-1:0]        data_nx;
  logic [PACK-1:0]          keep_nx;
  logic                     accept;
  logic                     last_elem;
  logic                     beat_end;
  logic signed [PSUM_BW:0]  rnd;
  logic signed [PSUM_BW:0]  sum;
  logic signed [PSUM_BW:0]  shr;
  logic [OUT_BW-1:0]        q;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [ENTRY_W-1:0]       fifo_din;
  logic [ENTRY_W-1:0]       fifo_dout;

  assign psum_ready = (state == RUN) && !fifo_full;
  assign accept     = psum_valid && psum_ready;
  assign last_elem  = (elem_cnt == total_q - CNT_W'(1));
  assign beat_end   = last_elem || (lane == LANE_W'(PACK - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
      done  <= (state_nx == DONE);
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = (total_cnt == '0) ? DONE : RUN;
      RUN:     if (accept && last_elem) state_nx = FLUSH;
      FLUSH:   if (fifo_empty) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Round-half-up requantization in one extra bit, then clamp to int8
  always_comb begin
    rnd = '0;
    if (shift_q != '0) rnd = (PSUM_BW + 1)'(1) << (shift_q - SHIFT_W'(1));
    sum = $signed({psum[PSUM_BW-1], psum}) + rnd;
    shr = sum >>> shift_q;
    if (shr > SAT_MAX)      q = OUT_BW'(INT8_MAX);
    else if (shr < SAT_MIN) q = OUT_BW'(INT8_MIN);
    else                    q = OUT_BW'(shr);
  end

  always_comb begin
    data_nx = beat_data;
    keep_nx = beat_keep;
    for (int i = 0; i < PACK; i++) begin
      if (lane == LANE_W'(i)) begin
        data_nx[i*OUT_BW +: OUT_BW] = q;
        keep_nx[i]                  = 1'b1;
      end
    end
  end

  // Beat accumulator is cleared after every push so partial beats zero-fill
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total_q   <= '0;
      shift_q   <= '0;
      elem_cnt  <= '0;
      lane      <= '0;
      beat_data <= '0;
      beat_keep <= '0;
    end else if (state == IDLE && start) begin
      total_q   <= total_cnt;
      shift_q   <= shift;
      elem_cnt  <= '0;
      lane      <= '0;
      beat_data <= '0;
      beat_keep <= '0;
    end else if (accept) begin
      elem_cnt <= elem_cnt + CNT_W'(1);
      if (beat_end) begin
        lane      <= '0;
        beat_data <= '0;
        beat_keep <= '0;
      end else begin
        lane      <= lane + LANE_W'(1);
        beat_data <= data_nx;
        beat_keep <= keep_nx;
      end
    end
  end

  assign fifo_din = {last_elem, keep_nx, data_nx};

  ofmap_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept && beat_end),
    .din   (fifo_din),
    .pop   (m_axis_tready),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_dout[DATA_W-1:0];
  assign m_axis_tkeep  = fifo_dout[DATA_W +: PACK];
  assign m_axis_tlast  = fifo_dout[ENTRY_W-1];

endmodule

// File: tb/tb_ofmap_tx.sv
// Bench for ofmap_tx: directed vector table, multi-cycle corner sequences and
// randomized transfers checked against an arithmetic reference model.
module tb_ofmap_tx;

  localparam int PACK   = 4;
  localparam int DEPTH  = 4;
  localparam int BUDGET = 3000;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] total_cnt;
  logic [4:0]  shift;
  logic        psum_valid;
  logic [31:0] psum;
  logic        psum_ready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        busy;
  logic        done;

  ofmap_tx dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .total_cnt     (total_cnt),
    .shift         (shift),
    .psum_valid    (psum_valid),
    .psum          (psum),
    .psum_ready    (psum_ready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    int          total;
    int          sh;
    int          p0, p1, p2, p3;
    logic [31:0] data;
    logic [3:0]  keep;
  } vec_t;

  int    n_cmp = 0;
  int    n_err = 0;
  int    plist[$];
  beat_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference requantizer in wide plain arithmetic
  function automatic logic [7:0] requant(input int p, input int sh);
    longint v;
    v = longint'(p);
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
    v = v >>> sh;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return 8'(v);
  endfunction

  function automatic void build_expected(input int total, input int sh);
    beat_t e;
    exp_q.delete();
    for (int b = 0; b * PACK < total; b++) begin
      e = '0;
      for (int l = 0; l < PACK; l++) begin
        if (b * PACK + l < total) begin
          e.data[l*8 +: 8] = requant(plist[b*PACK + l], sh);
          e.keep[l]        = 1'b1;
        end
      end
      e.last = (b * PACK + PACK >= total);
      exp_q.push_back(e);
    end
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_psum_ready"}, 32'(psum_ready), 32'd0);
    chk({tag, "_tvalid"},     32'(m_axis_tvalid), 32'd0);
    chk({tag, "_tlast"},      32'(m_axis_tlast), 32'd0);
    chk({tag, "_tkeep"},      32'(m_axis_tkeep), 32'd0);
    chk({tag, "_tdata"},      m_axis_tdata, 32'd0);
    chk({tag, "_busy"},       32'(busy), 32'd0);
    chk({tag, "_done"},       32'(done), 32'd0);
  endtask

  // Runs one transfer of plist; tready is held low for the first 'stall' cycles
  task automatic run_xfer(input string tag, input int total, input int sh,
                          input int vpct, input int rpct, input int stall,
                          output logic [31:0] ldata, output logic [3:0] lkeep,
                          output logic llast);
    int          idx;
    bit          ok;
    bit          stalled;
    beat_t       prev;
    beat_t       e;
    int          lim;
    ldata = '0;
    lkeep = '0;
    llast = 1'b0;
    build_expected(total, sh);
    idx     = 0;
    ok      = 1'b0;
    stalled = 1'b0;
    prev    = '0;
    @(negedge clk);
    start         = 1'b1;
    total_cnt     = 16'(total);
    shift         = 5'(sh);
    psum_valid    = 1'b0;
    m_axis_tready = 1'b0;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        chk({tag, "_hold_tvalid"}, 32'(m_axis_tvalid), 32'd1);
        chk({tag, "_hold_beat"}, 32'({m_axis_tdata[26:0], m_axis_tkeep, m_axis_tlast}),
            32'({prev.data[26:0], prev.keep, prev.last}));
        chk({tag, "_hold_top"}, 32'(m_axis_tdata[31:27]), 32'(prev.data[31:27]));
      end
      if (done) begin
        ok = 1'b1;
        break;
      end
      start         = ($urandom_range(0, 7) == 0);
      total_cnt     = 16'($urandom);
      shift         = 5'($urandom);
      psum_valid    = (idx < total) && ($urandom_range(1, 100) <= vpct);
      psum          = psum_valid ? 32'(plist[idx]) : $urandom;
      m_axis_tready = (cyc >= stall) && ($urandom_range(1, 100) <= rpct);
      if (stall > 0 && cyc == stall && vpct == 100) begin
        lim = (total < DEPTH * PACK) ? total : DEPTH * PACK;
        chk({tag, "_stall_accepted"}, 32'(idx), 32'(lim));
        if (total >= DEPTH * PACK) chk({tag, "_stall_ready"}, 32'(psum_ready), 32'd0);
      end
      stalled = m_axis_tvalid && !m_axis_tready;
      prev    = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk({tag, "_unexpected_beat"}, m_axis_tdata, 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          chk({tag, "_tdata"}, m_axis_tdata, e.data);
          chk({tag, "_tkeep"}, 32'(m_axis_tkeep), 32'(e.keep));
          chk({tag, "_tlast"}, 32'(m_axis_tlast), 32'(e.last));
          ldata = m_axis_tdata;
          lkeep = m_axis_tkeep;
          llast = m_axis_tlast;
        end
      end
      if (psum_valid && psum_ready) idx++;
    end
    start         = 1'b0;
    psum_valid    = 1'b0;
    m_axis_tready = 1'b0;
    if (!ok) chk({tag, "_timeout_done"}, 32'd0, 32'd1);
    chk({tag, "_accepted"}, 32'(idx), 32'(total));
    chk({tag, "_beats_left"}, 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_done_after"}, 32'(done), 32'd0);
  endtask

  vec_t        vecs[7];
  logic [31:0] ld;
  logic [3:0]  lk;
  logic        ll;

  initial begin
    vecs[0] = '{4, 0, 1, -1, 127, -128, 32'h807F_FF01, 4'hF};
    vecs[1] = '{1, 4, 24, 0, 0, 0, 32'h0000_0002, 4'h1};
    vecs[2] = '{2, 0, 300, -1000, 0, 0, 32'h0000_807F, 4'h3};
    vecs[3] = '{3, 1, 3, -3, 255, 0, 32'h007F_FF02, 4'h7};
    vecs[4] = '{4, 2, 5, -5, -512, 511, 32'h7F80_FF01, 4'hF};
    vecs[5] = '{2, 31, int'(32'h7FFF_FFFF), int'(32'h8000_0000), 0, 0, 32'h0000_FF01, 4'h3};
    vecs[6] = '{4, 0, -129, 128, 0, -128, 32'h8000_7F80, 4'hF};

    reset         = 1'b1;
    start         = 1'b0;
    total_cnt     = '0;
    shift         = '0;
    psum_valid    = 1'b0;
    psum          = '0;
    m_axis_tready = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    // Directed single-beat vectors at full throughput
    for (int v = 0; v < 7; v++) begin
      plist = {vecs[v].p0, vecs[v].p1, vecs[v].p2, vecs[v].p3};
      run_xfer($sformatf("vec%0d", v), vecs[v].total, vecs[v].sh, 100, 100, 0, ld, lk, ll);
      chk($sformatf("vec%0d_tbl_data", v), ld, vecs[v].data);
      chk($sformatf("vec%0d_tbl_keep", v), 32'(lk), 32'(vecs[v].keep));
      chk($sformatf("vec%0d_tbl_last", v), 32'(ll), 32'd1);
    end

    // Empty transfer goes straight to DONE
    @(negedge clk);
    start     = 1'b1;
    total_cnt = 16'd0;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd1);
    chk("zero_tvalid", 32'(m_axis_tvalid), 32'd0);
    @(negedge clk);
    chk("zero_done_end", 32'(done), 32'd0);
    chk("zero_busy_end", 32'(busy), 32'd0);
    chk("zero_tvalid_end", 32'(m_axis_tvalid), 32'd0);

    // Backpressure: 32 elements with tready low fills the FIFO with 4 beats
    plist.delete();
    for (int i = 0; i < 32; i++) plist.push_back(i * 7 - 100);
    run_xfer("bp", 32, 0, 100, 100, 40, ld, lk, ll);

    // Reset in the middle of a transfer, then a clean restart
    @(negedge clk);
    start     = 1'b1;
    total_cnt = 16'd16;
    shift     = 5'd0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      psum_valid = 1'b1;
      psum       = 32'(i + 1);
      @(negedge clk);
    end
    psum_valid = 1'b0;
    chk("midrst_pre_tvalid", 32'(m_axis_tvalid), 32'd1);
    chk("midrst_pre_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1 check_idle_outputs("midrst");
    @(negedge clk);
    reset = 1'b0;
    plist = {vecs[0].p0, vecs[0].p1, vecs[0].p2, vecs[0].p3};
    run_xfer("after_rst", 4, 0, 100, 100, 0, ld, lk, ll);
    chk("after_rst_data", ld, 32'h807F_FF01);

    // Randomized transfers against the reference model
    for (int t = 0; t < 25; t++) begin
      int total;
      int sh;
      total = $urandom_range(0, 40);
      sh    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 8);
      plist.delete();
      for (int i = 0; i < total; i++) begin
        if ($urandom_range(0, 1) == 0) plist.push_back($urandom_range(0, 600) - 300);
        else                           plist.push_back(int'($urandom));
      end
      run_xfer($sformatf("rnd%0d", t), total, sh, $urandom_range(30, 100),
               $urandom_range(30, 100), 0, ld, lk, ll);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ofmap_tx.md
OFMAP_TX -- requirements
Module: ofmap_tx

Interface
REQ-001 SHALL have parameter PSUM_BW, default 32, psum input width.
REQ-002 SHALL have parameter OUT_BW, default 8, quantized element width.
REQ-003 SHALL have parameter PACK, default 4, elements per output beat.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, output beat buffer depth.
REQ-005 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port start  in  1  one-cycle pulse that begins a transfer.
REQ-008 SHALL have port total_cnt  in  16  number of psum elements in the transfer.
REQ-009 SHALL have port shift  in  5  requantization right-shift amount.
REQ-010 SHALL have port psum_valid  in  1  psum element offered by the PE network.
REQ-011 SHALL have port psum  in  PSUM_BW  signed psum element.
REQ-012 SHALL have port psum_ready  out  1  element accepted when psum_valid and psum_ready are both high.
REQ-013 SHALL have port m_axis_tdata  out  PACK*OUT_BW  packed int8 output beat.
REQ-014 SHALL have port m_axis_tkeep  out  PACK  valid byte lanes.
REQ-015 SHALL have port m_axis_tlast  out  1  final beat of the transfer.
REQ-016 SHALL have port m_axis_tvalid  out  1  beat valid.
REQ-017 SHALL have port m_axis_tready  in  1  downstream accepts the beat.
REQ-018 SHALL have ports busy and done  out  1 each; busy is high outside IDLE, and done is a one-cycle completion pulse.

Function
REQ-019 SHALL implement FSM IDLE->RUN on start, RUN->FLUSH after total_cnt elements are accepted, FLUSH->DONE when the FIFO is empty, and DONE->IDLE after one cycle.
REQ-020 SHALL latch total_cnt and shift on start, so later input changes do not affect the transfer in progress.
REQ-021 SHALL ignore start outside IDLE.
REQ-022 SHALL go IDLE->DONE directly on start with total_cnt=0, emitting no beats.
REQ-023 SHALL drive psum_ready = (state==RUN) && !fifo_full, with no combinational path from m_axis_tready.
REQ-024 SHALL requantize each element as q = (psum + (shift>0 ? 2^(shift-1) : 0)) >>> shift, computed in PSUM_BW+1 bits to avoid overflow.
REQ-025 SHALL saturate q to [-128, 127].
REQ-026 SHALL place the element with index n in byte lane n mod PACK, with lane 0 at bits [7:0].
REQ-027 SHALL push a beat to the FIFO when lane PACK-1 fills or the last element is accepted.
REQ-028 SHALL zero-fill unused lanes of a partial final beat and clear the matching tkeep bits.
REQ-029 SHALL set tlast only on the beat that contains element total_cnt-1.
REQ-030 SHALL raise m_axis_tvalid on the cycle after the push of the beat, when the FIFO was empty.
REQ-031 SHALL hold tdata, tkeep and tlast stable while tvalid=1 and tready=0.
REQ-032 SHALL handle a push and a pop in the same cycle without loss, leaving the FIFO count unchanged.
REQ-033 SHALL wrap the FIFO pointers modulo FIFO_DEPTH.
REQ-034 SHALL never assert psum_ready while the FIFO is full, even if a pop occurs in that cycle.

Reset
REQ-035 SHALL, on reset assertion at any time including mid-transfer, immediately go to state IDLE.
REQ-036 SHALL, on reset, empty the FIFO and clear the lane and element counters.
REQ-037 SHALL, on reset, drive psum_ready, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, busy and done to 0.
REQ-038 SHALL discard any partial beat after reset, with no beat emitted.

Structure
REQ-039 SHALL place the FSM state encoding and the INT8 min/max constants in the shared NPU package.
REQ-040 SHALL implement the output buffer as one sub-module, ofmap_fifo, a synchronous FIFO of width PACK*OUT_BW+PACK+1 and depth FIFO_DEPTH.

Verification
REQ-041 SHALL cover: total_cnt=4, shift=0, psums 1,-1,127,-128 with tready=1 -> one beat, tdata=0x807FFF01, tkeep=0xF, tlast=1, then a done pulse.
REQ-042 SHALL cover: total_cnt=1, shift=4, psum=24 -> (24+8)>>4=2, so tdata=0x00000002, tkeep=0x1, tlast=1.
REQ-043 SHALL cover: psums 300 and -1000 at shift=0 -> saturated to 0x7F and 0x80.
REQ-044 SHALL cover: total_cnt=32 with tready held 0 -> psum_ready drops after 4 beats are buffered, and all 8 beats arrive in order once tready=1.
REQ-045 SHALL cover: total_cnt=0 with a start pulse -> done one cycle later and no tvalid.
REQ-046 SHALL cover: reset asserted after 6 of 16 elements -> all outputs 0 immediately, and a new start with total_cnt=4 produces a single correct beat.
